// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG DC entropy path: tuple layout, size-0 sentinel,
// symbol width bound and the bit packer state encoding.
package jpeg_pkg;

   localparam int CODE_MSB        = 23;
   localparam int LEN_MSB         = 15;
   localparam int AMP_MSB         = 7;
   localparam logic [7:0] SIZE0_SENTINEL = 8'hFF;
   localparam int MAX_SYMBOL_BITS = 16;

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STUFF = 2'd1,
      S_FLUSH = 2'd2
   } pack_state_t;

endpackage

// File: rtl/jpeg_bitlen.sv
// Amplitude bit-length encoder: index of the highest set bit plus one,
// forced to zero for the size-0 sentinel value.
module jpeg_bitlen
   import jpeg_pkg::*;
(
   input  logic [7:0] amp,
   output logic [3:0] amp_len
);

   always_comb begin
      amp_len = 4'd0;
      if (amp != SIZE0_SENTINEL) begin
         for (int i = 0; i < 8; i++) begin
            if (amp[i]) amp_len = 4'(i + 1);
         end
      end
   end

endmodule

// File: rtl/jpeg_bitpacker.sv
// Packs DC Huffman tuples into an entropy-coded byte stream with 1-padding on flush.
// Define JPEG_BYTE_STUFF_EN to insert 0x00 after every emitted 0xFF.
//
// state   | meaning
// S_RUN   | accept symbols, pop whole bytes
// S_STUFF | emit the 0x00 that follows a 0xFF byte
// S_FLUSH | drain bytes, pad last partial byte with 1s, then pulse flush_done
module jpeg_bitpacker
   import jpeg_pkg::*;
#(
   parameter int ACC_W = 32
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [23:0] in_tuple,
   input  logic        flush,
   output logic        flush_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_byte,
   output logic [5:0]  fill
);

   pack_state_t      state;
   logic             flush_pend;
   logic [ACC_W-1:0] acc, sym_ext, merged;
   logic [7:0]       code, len_raw, amp, code_bits, amp_bits, head, pad_byte;
   logic [3:0]       code_len, amp_len;
   logic [8:0]       amp_mask;
   logic [4:0]       nbits, amp_sh;
   logic [15:0]      sym;
   logic [6:0]       total;
   logic             accept, out_free, pop, stuff_pop, stuff_pad;

   assign code    = in_tuple[CODE_MSB -: 8];
   assign len_raw = in_tuple[LEN_MSB -: 8];
   assign amp     = in_tuple[AMP_MSB -: 8];

   jpeg_bitlen u_bitlen (
      .amp     (amp),
      .amp_len (amp_len)
   );

   assign code_len  = (len_raw > 8'd8) ? 4'd8 : len_raw[3:0];
   assign code_bits = code & ~(8'hFF >> code_len);
   assign amp_mask  = (9'd1 << amp_len) - 9'd1;
   assign amp_bits  = amp & amp_mask[7:0];
   assign nbits     = {1'b0, code_len} + {1'b0, amp_len};
   assign amp_sh    = 5'(MAX_SYMBOL_BITS) - nbits;
   // Symbol is MSB-aligned: code bits first, amplitude bits directly behind them.
   assign sym       = {code_bits, 8'h00} | ({8'h00, amp_bits} << amp_sh);
   assign sym_ext   = {sym, {(ACC_W-16){1'b0}}} >> fill;

   assign in_ready = !rst && (state == S_RUN) && !flush_pend
                     && (int'(fill) <= ACC_W - MAX_SYMBOL_BITS);
   assign accept   = in_valid && in_ready;
   assign out_free = !out_valid || out_ready;

   // Merging before the pop lets a fresh symbol's first byte leave in the same cycle.
   assign merged   = accept ? (acc | sym_ext) : acc;
   assign total    = {1'b0, fill} + (accept ? {2'b00, nbits} : 7'd0);
   assign head     = merged[ACC_W-1 -: 8];
   assign pop      = ((state == S_RUN) || (state == S_FLUSH)) && out_free && (total >= 7'd8);
   assign pad_byte = acc[ACC_W-1 -: 8] | (8'hFF >> fill[2:0]);

`ifdef JPEG_BYTE_STUFF_EN
   assign stuff_pop = (head == 8'hFF);
   assign stuff_pad = (pad_byte == 8'hFF);
`else
   assign stuff_pop = 1'b0;
   assign stuff_pad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_RUN;
         acc        <= '0;
         fill       <= '0;
         flush_pend <= 1'b0;
         flush_done <= 1'b0;
         out_valid  <= 1'b0;
         out_byte   <= 8'h00;
      end else begin
         flush_done <= 1'b0;
         if (flush) flush_pend <= 1'b1;
         if (out_valid && out_ready) out_valid <= 1'b0;
         case (state)
            S_RUN, S_FLUSH: begin
               if (pop) begin
                  out_byte  <= head;
                  out_valid <= 1'b1;
                  acc       <= merged << 8;
                  fill      <= 6'(total - 7'd8);
               end else begin
                  acc  <= merged;
                  fill <= total[5:0];
               end
               if (pop && stuff_pop) begin
                  state <= S_STUFF;
               end else if (state == S_RUN) begin
                  if (flush_pend) state <= S_FLUSH;
               end else if (!pop && out_free) begin
                  if (fill != 6'd0) begin
                     out_byte  <= pad_byte;
                     out_valid <= 1'b1;
                     acc       <= '0;
                     fill      <= '0;
                     // flush_pend stays set, so the stuff path comes back here to finish.
                     if (stuff_pad) state <= S_STUFF;
                  end else begin
                     flush_done <= 1'b1;
                     flush_pend <= 1'b0;
                     state      <= S_RUN;
                  end
               end
            end
`ifdef JPEG_BYTE_STUFF_EN
            S_STUFF: begin
               if (out_free) begin
                  out_byte  <= 8'h00;
                  out_valid <= 1'b1;
                  state     <= S_RUN;
               end
            end
`endif
            default: state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_jpeg_bitpacker.sv
// Self-checking bench for jpeg_bitpacker: bit-queue reference model plus directed
// and randomized scenarios. Honours JPEG_BYTE_STUFF_EN like the design.
module tb_jpeg_bitpacker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] in_tuple = 24'h0;
   logic        flush = 1'b0;
   logic        flush_done;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [7:0]  out_byte;
   logic [5:0]  fill;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   bit model_pend = 1'b0;

   logic [7:0] got_q[$];
   logic [7:0] exp_q[$];
   bit         bits_q[$];

   always #5 clk = ~clk;

   jpeg_bitpacker #(.ACC_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_tuple   (in_tuple),
      .flush      (flush),
      .flush_done (flush_done),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_byte   (out_byte),
      .fill       (fill)
   );

   // ---------------- reference model: a plain bit queue ----------------
   function automatic void push_exp(input logic [7:0] b);
      exp_q.push_back(b);
`ifdef JPEG_BYTE_STUFF_EN
      if (b == 8'hFF) exp_q.push_back(8'h00);
`endif
   endfunction

   function automatic void drain_bits();
      logic [7:0] b;
      while (bits_q.size() >= 8) begin
         b = 8'h00;
         for (int i = 0; i < 8; i++) b = {b[6:0], bits_q.pop_front()};
         push_exp(b);
      end
   endfunction

   function automatic void model_sym(input logic [23:0] t);
      int cl, al;
      logic [7:0] code, amp;
      code = t[23:16];
      amp  = t[7:0];
      cl   = (t[15:8] > 8) ? 8 : int'(t[15:8]);
      al   = (amp == 8'hFF) ? 0 : $clog2(int'(amp) + 1);
      for (int i = 0; i < cl; i++) bits_q.push_back(code[7-i]);
      for (int i = al - 1; i >= 0; i--) bits_q.push_back(amp[i]);
      drain_bits();
   endfunction

   function automatic void model_flush();
      if (bits_q.size() > 0) begin
         while (bits_q.size() < 8) bits_q.push_back(1'b1);
         drain_bits();
      end
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) got_q.push_back(out_byte);
         if (in_valid && in_ready) model_sym(in_tuple);
         if (flush_done) begin
            done_cnt++;
            model_pend = 1'b0;
         end
         if (flush && !model_pend) begin
            model_pend = 1'b1;
            model_flush();
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input logic [23:0] t);
      int n;
      in_tuple = t;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL send_timeout tuple=%06h in_ready never rose", t);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int start, n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < 300) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (done_cnt == start) begin
         bad++;
         $display("FAIL %s flush_done_timeout pulses=%0d want>=1", name, done_cnt - start);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_stream(input string name);
      int n;
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL %s byte_count got=%0d want=%0d", name, got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL %s byte[%0d] got=%02h want=%02h", name, i, got_q[i], exp_q[i]);
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      out_ready = 1'b1;
      got_q.delete(); exp_q.delete(); bits_q.delete();
      model_pend = 1'b0;
      @(posedge clk); @(negedge clk);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      apply_reset();
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_byte !== 8'h00 ||
          fill !== 6'd0 || flush_done !== 1'b0) begin
         bad++;
         $display("FAIL reset_hold in_ready=%b out_valid=%b out_byte=%02h fill=%0d flush_done=%b want 0/0/00/0/0",
                  in_ready, out_valid, out_byte, fill, flush_done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || fill !== 6'd0) begin
         bad++;
         $display("FAIL reset_release in_ready=%b out_valid=%b fill=%0d want 1/0/0", in_ready, out_valid, fill);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_basic_flush();
      int start;
      start = done_cnt;
      send({8'hC0, 8'h03, 8'h05});
      pulse_flush();
      wait_done("basic");
      total++;
      if (got_q.size() != 1 || got_q[0] !== 8'hD7) begin
         bad++;
         $display("FAIL basic_pad_byte count=%0d first=%02h want 1 byte D7 before flush_done",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
      end
      idle(3);
      total++;
      if (done_cnt - start != 1) begin
         bad++;
         $display("FAIL basic_done_pulses got=%0d want=1", done_cnt - start);
      end
      check_stream("basic");
   endtask

   task automatic test_full_width();
      send({8'hAA, 8'h08, 8'h80});
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_byte !== 8'hAA) begin
         bad++;
         $display("FAIL full_first valid=%b byte=%02h want 1/AA", out_valid, out_byte);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_byte !== 8'h80) begin
         bad++;
         $display("FAIL full_second valid=%b byte=%02h want 1/80", out_valid, out_byte);
      end
      idle(3);
      check_stream("full_width");
   endtask

   task automatic test_stuff();
      logic exp_rdy;
`ifdef JPEG_BYTE_STUFF_EN
      exp_rdy = 1'b0;
`else
      exp_rdy = 1'b1;
`endif
      send({8'hFF, 8'h08, 8'hFF});
      @(negedge clk);
      total++;
      if (out_byte !== 8'hFF || out_valid !== 1'b1 || in_ready !== exp_rdy) begin
         bad++;
         $display("FAIL stuff_ff byte=%02h valid=%b in_ready=%b want FF/1/%b", out_byte, out_valid, in_ready, exp_rdy);
      end
      @(negedge clk);
      total++;
`ifdef JPEG_BYTE_STUFF_EN
      if (out_valid !== 1'b1 || out_byte !== 8'h00) begin
         bad++;
         $display("FAIL stuff_zero valid=%b byte=%02h want 1/00", out_valid, out_byte);
      end
`else
      if (out_valid !== 1'b0) begin
         bad++;
         $display("FAIL stuff_none valid=%b want 0", out_valid);
      end
`endif
      idle(3);
      check_stream("stuff");
   endtask

   task automatic test_backpressure();
      bit         have_prev, saw_stall;
      logic [7:0] prev;
      have_prev = 1'b0;
      saw_stall = 1'b0;
      prev = 8'h00;
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 4; k++)
               send({8'($urandom), 8'h08, 8'h80 | 8'($urandom_range(0, 126))});
         end
         begin
            idle(6);
            out_ready = 1'b1;
         end
         begin
            repeat (10) begin
               @(negedge clk);
               if (have_prev && out_valid) begin
                  total++;
                  if (out_byte !== prev) begin
                     bad++;
                     $display("FAIL bp_hold byte=%02h want=%02h", out_byte, prev);
                  end
               end
               total++;
               if (fill > 6'd16 && in_ready) begin
                  bad++;
                  $display("FAIL bp_ready fill=%0d in_ready=%b want 0", fill, in_ready);
               end
               if (in_valid && !in_ready) saw_stall = 1'b1;
               have_prev = out_valid && !out_ready;
               prev = out_byte;
            end
         end
      join
      idle(10);
      total++;
      if (!saw_stall) begin
         bad++;
         $display("FAIL bp_stall in_ready_drop=0 want 1");
      end
      check_stream("backpressure");
   endtask

   task automatic test_saturation();
      send({8'hF8, 8'h09, 8'hFF});
      pulse_flush();
      wait_done("saturation");
      idle(2);
      total++;
      if (got_q.size() != 1 || got_q[0] !== 8'hF8) begin
         bad++;
         $display("FAIL sat_byte count=%0d first=%02h want 1 byte F8",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
      end
      check_stream("saturation");
   endtask

   task automatic test_random();
      bit drv_done;
      int start;
      drv_done = 1'b0;
      start = done_cnt;
      fork
         begin
            for (int k = 0; k < 24; k++) begin
               logic [7:0] a;
               a = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
               send({8'($urandom), 8'($urandom_range(0, 10)), a});
            end
            pulse_flush();
            pulse_flush();
            wait_done("random");
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      idle(8);
      total++;
      if (done_cnt - start != 1) begin
         bad++;
         $display("FAIL random_done_pulses got=%0d want=1", done_cnt - start);
      end
      check_stream("random");
   endtask

   task automatic test_reset_mid_flush();
      int start;
      out_ready = 1'b0;
      send({8'hF8, 8'h05, 8'hA5});
      pulse_flush();
      idle(3);
      @(negedge clk);
      total++;
      if (fill !== 6'd5 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rmf_setup fill=%0d valid=%b want 5/1", fill, out_valid);
      end
      @(posedge clk); #1;
      start = done_cnt;
      apply_reset();
      total++;
      if (out_valid !== 1'b0 || fill !== 6'd0) begin
         bad++;
         $display("FAIL rmf_cleared valid=%b fill=%0d want 0/0", out_valid, fill);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || fill !== 6'd0) begin
         bad++;
         $display("FAIL rmf_after in_ready=%b valid=%b fill=%0d want 1/0/0", in_ready, out_valid, fill);
      end
      idle(8);
      total++;
      if (done_cnt != start || got_q.size() != 0) begin
         bad++;
         $display("FAIL rmf_no_done pulses=%0d bytes=%0d want 0/0", done_cnt - start, got_q.size());
      end
      check_stream("reset_mid_flush");
   endtask

   initial begin
      test_reset();
      test_basic_flush();
      test_full_width();
      test_stuff();
      test_backpressure();
      test_saturation();
      test_random();
      test_reset_mid_flush();
      test_basic_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout sim time exceeded");
      $fatal(1);
   end

endmodule
